// File: rtl/sipo_framed.sv
// Serial-in/parallel-out deserialiser with qualified input bits, a word holding register and
// valid/ready output handshake. Define SIPO_PARITY_EN to append a trailing even-parity bit per frame.
module sipo_framed #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sdi,
    input  logic             sdi_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             busy,
    output logic             overrun
`ifdef SIPO_PARITY_EN
    ,
    output logic             parity_err
`endif
);

`ifdef SIPO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] shifted_s;
    logic             done_s;
`ifdef SIPO_PARITY_EN
    logic             perr_q, perr_d;

    function automatic logic parity_mismatch(input logic [WIDTH-1:0] data, input logic pbit);
        return (^data) ^ pbit;
    endfunction
`endif

    // Next-state logic: bit assembly, word completion, handshake and overrun tracking
    always_comb begin
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
`ifdef SIPO_PARITY_EN
        perr_d  = perr_q;
`endif
        shifted_s = LSB_FIRST ? {sdi, sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], sdi};
        done_s    = sdi_valid && (cnt_q == LAST);
        if (clear) begin
            sh_d    = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
`ifdef SIPO_PARITY_EN
            perr_d  = 1'b0;
`endif
        end else begin
            if (sdi_valid) begin
                if (done_s) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`ifdef SIPO_PARITY_EN
                // The trailing parity bit is checked but never enters the shift register
                if (done_s) begin
                    sh_d = sh_q;
                end else begin
                    sh_d = shifted_s;
                end
`else
                sh_d = shifted_s;
`endif
            end else begin
                sh_d  = sh_q;
                cnt_d = cnt_q;
            end
            if (done_s) begin
`ifdef SIPO_PARITY_EN
                q_d    = sh_q;
                perr_d = parity_mismatch(sh_q, sdi);
`else
                q_d    = shifted_s;
`endif
                valid_d = 1'b1;
                if (valid_q && !q_ready) begin
                    ovr_d = 1'b1;
                end else begin
                    ovr_d = ovr_q;
                end
            end else if (valid_q && q_ready) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
        end
        busy_d = (cnt_d != '0);
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SIPO_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
`ifdef SIPO_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign q       = q_q;
    assign q_valid = valid_q;
    assign overrun = ovr_q;
    assign busy    = busy_q;
`ifdef SIPO_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_sipo_framed.sv
// Bench for sipo_framed: MSB-first and LSB-first instances share one input stream and are
// compared every cycle against a bit-queue reference model, plus directed scenario checks.
module tb_sipo_framed;
    localparam int W = 8;
`ifdef SIPO_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sdi = 1'b0, sdi_valid = 1'b0, clear = 1'b0, q_ready = 1'b0;
    logic [W-1:0] q_m, q_l;
    logic qv_m, qv_l, busy_m, busy_l, ovr_m, ovr_l;
`ifdef SIPO_PARITY_EN
    logic perr_m, perr_l;
`endif

    sipo_framed #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .reset(reset), .sdi(sdi), .sdi_valid(sdi_valid), .clear(clear),
        .q(q_m), .q_valid(qv_m), .q_ready(q_ready), .busy(busy_m), .overrun(ovr_m)
`ifdef SIPO_PARITY_EN
        , .parity_err(perr_m)
`endif
    );

    sipo_framed #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .reset(reset), .sdi(sdi), .sdi_valid(sdi_valid), .clear(clear),
        .q(q_l), .q_valid(qv_l), .q_ready(q_ready), .busy(busy_l), .overrun(ovr_l)
`ifdef SIPO_PARITY_EN
        , .parity_err(perr_l)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: bits received in the current frame, in arrival order
    bit           bits[$];
    logic [W-1:0] mq_m = '0;
    logic [W-1:0] mq_l = '0;
    logic         m_valid = 1'b0;
    logic         m_ovr = 1'b0;
    logic         m_perr = 1'b0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        bits.delete();
        mq_m = '0;
        mq_l = '0;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        m_perr = 1'b0;
    endtask

    task automatic model_step(input logic b, input logic v, input logic c, input logic r);
        bit done;
        if (c) begin
            bits.delete();
            m_valid = 1'b0;
            m_ovr = 1'b0;
            m_perr = 1'b0;
        end else begin
            done = v && (bits.size() == FRAME - 1);
            if (v) bits.push_back(b);
            if (done) begin
                for (int i = 0; i < W; i++) begin
                    mq_m[W-1-i] = bits[i];
                    mq_l[i] = bits[i];
                end
                if (m_valid && !r) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_perr = 1'b0;
                if (FRAME > W) m_perr = (^mq_m) ^ bits[FRAME-1];
                bits.delete();
            end else if (r) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        check("q_msb", q_m, mq_m);
        check("q_lsb", q_l, mq_l);
        check("q_valid_msb", W'(qv_m), W'(m_valid));
        check("q_valid_lsb", W'(qv_l), W'(m_valid));
        check("busy_msb", W'(busy_m), W'(bits.size() != 0));
        check("busy_lsb", W'(busy_l), W'(bits.size() != 0));
        check("overrun_msb", W'(ovr_m), W'(m_ovr));
        check("overrun_lsb", W'(ovr_l), W'(m_ovr));
`ifdef SIPO_PARITY_EN
        check("parity_err_msb", W'(perr_m), W'(m_perr));
        check("parity_err_lsb", W'(perr_l), W'(m_perr));
`endif
    endtask

    task automatic cycle(input logic b, input logic v, input logic c, input logic r);
        sdi = b;
        sdi_valid = v;
        clear = c;
        q_ready = r;
        @(posedge clk);
        model_step(b, v, c, r);
        #1 check_all();
    endtask

    // Sends w first-bit = w[W-1], then the even-parity bit (optionally corrupted) when enabled
    task automatic send_word(input logic [W-1:0] w, input int gap, input logic r_mid,
                             input logic r_last, input logic bad_par);
        logic b;
        for (int i = 0; i < FRAME; i++) begin
            if (i < W) b = w[W-1-i];
            else b = (^w) ^ bad_par;
            cycle(b, 1'b1, 1'b0, (i == FRAME - 1) ? r_last : r_mid);
            if (i < FRAME - 1) begin
                for (int g = 0; g < gap; g++) cycle(1'($urandom_range(1, 0)), 1'b0, 1'b0, r_mid);
            end
        end
    endtask

    task automatic hold_reset_and_release();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        hold_reset_and_release();

        // Stream 1,0,1,1,0,0,1,0 back-to-back with consumer always ready
        send_word(8'hB2, 0, 1'b1, 1'b1, 1'b0);
        check("s1_q_msb_const", q_m, 8'hB2);
        check("s1_q_lsb_const", q_l, 8'h4D);
        check("s1_valid_const", W'(qv_m), 8'h01);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("s1_valid_cleared", W'(qv_m), 8'h00);

        // Same stream with 3-cycle gaps and random sdi during gaps
        send_word(8'hB2, 3, 1'b1, 1'b1, 1'b0);
        check("s2_q_lsb_const", q_l, 8'h4D);

        // Overrun: two words with no consumer, newest wins, then clear
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        send_word(8'hB2, 0, 1'b0, 1'b0, 1'b0);
        send_word(8'h0F, 0, 1'b0, 1'b0, 1'b0);
        check("s3_q_const", q_m, 8'h0F);
        check("s3_ovr_const", W'(ovr_m), 8'h01);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("s3_ovr_cleared", W'(ovr_m), 8'h00);
        check("s3_valid_cleared", W'(qv_m), 8'h00);
        check("s3_q_kept", q_m, 8'h0F);

        // Partial word flushed by clear colliding with a valid bit
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("s4_busy_after_clear", W'(busy_m), 8'h00);
        send_word(8'hA5, 0, 1'b1, 1'b1, 1'b0);
        check("s4_q_after_clear", q_m, 8'hA5);

        // Partial word discarded by an asynchronous mid-cycle reset
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        model_reset();
        check("s4_busy_async_reset", W'(busy_m), 8'h00);
        check_all();
        hold_reset_and_release();
        send_word(8'hA5, 0, 1'b1, 1'b1, 1'b0);
        check("s4_q_after_reset", q_m, 8'hA5);

        // Acceptance and completion on the same edge
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        send_word(8'h11, 0, 1'b0, 1'b0, 1'b0);
        send_word(8'h3C, 0, 1'b0, 1'b1, 1'b0);
        check("s5_q_const", q_m, 8'h3C);
        check("s5_valid_const", W'(qv_m), 8'h01);
        check("s5_ovr_const", W'(ovr_m), 8'h00);

`ifdef SIPO_PARITY_EN
        send_word(8'hB2, 0, 1'b1, 1'b1, 1'b0);
        check("s6_perr_good", W'(perr_m), 8'h00);
        send_word(8'hB2, 0, 1'b1, 1'b1, 1'b1);
        check("s6_perr_bad", W'(perr_m), 8'h01);
        check("s6_q_excludes_parity", q_m, 8'hB2);
`endif

        // Randomised traffic with gaps, back-pressure and occasional clears
        for (int i = 0; i < 500; i++) begin
            cycle(1'($urandom_range(1, 0)), 1'($urandom_range(3, 0) != 0),
                  1'($urandom_range(63, 0) == 0), 1'($urandom_range(2, 0) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
